// File: rtl/i2c_loop_design.sv
// I2C loopback: bit-level master and a 128x8 register slave sharing an internal open-drain bus.
// Optional bus observation ports scl_o/sda_o are enabled by defining I2C_BUS_OBS_EN.
module i2c_loop_design #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [6:0] addr,
  output logic [7:0] rdata,
  output logic       done
`ifdef I2C_BUS_OBS_EN
  ,
  output logic       scl_o,
  output logic       sda_o
`endif
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WDATA,
    M_WACK, M_RDATA, M_MNACK, M_STOP, M_DONE
  } m_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_WAIT
  } s_state_e;

  // Master state
  m_state_e        m_state_q, m_state_d;
  logic [CW-1:0]   cdiv_q, cdiv_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            wr_q, wr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            scl_q, scl_d;
  logic            m_drv_q, m_drv_d;
  logic            newd_prev_q;

  // Slave state
  s_state_e        s_state_q, s_state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [7:0]      s_sh_q, s_sh_d;
  logic [6:0]      s_addr_q, s_addr_d;
  logic            s_rw_q, s_rw_d;
  logic            s_drv_q, s_drv_d;
  logic            s_scl_prev_q, s_sda_prev_q;
  logic [7:0]      mem_q [128];
  logic            mem_we;
  logic [7:0]      mem_wdata;

  // Resolved open-drain bus: a drive-enable pulls the line low.
  logic sda_bus;
  assign sda_bus = ~(m_drv_q | s_drv_q);

  logic tick, bit_end, scl_hi_qtr;
  assign tick       = (cdiv_q == CW'(CLK_DIV - 1));
  assign bit_end    = tick && (qtr_q == 2'd3);
  assign scl_hi_qtr = (qtr_q == 2'd1) || (qtr_q == 2'd2);

  always_comb begin
    m_state_d = m_state_q;
    cdiv_d    = cdiv_q;
    qtr_d     = qtr_q;
    bcnt_d    = bcnt_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    scl_d     = 1'b1;
    m_drv_d   = 1'b0;

    case (m_state_q)
      M_IDLE: begin
        if (newd && !newd_prev_q) begin
          m_state_d = M_START;
          cdiv_d    = '0;
          qtr_d     = 2'd0;
          bcnt_d    = 3'd0;
          wr_d      = wr;
          wdata_d   = wdata;
          tx_sh_d   = {addr, ~wr};
        end
      end
      M_DONE: begin
        done_d    = 1'b1;
        m_state_d = M_IDLE;
        if (!wr_q) rdata_d = rx_sh_q;
      end
      default: begin
        cdiv_d = tick ? '0 : cdiv_q + 1'b1;
        if (tick) qtr_d = qtr_q + 2'd1;
        // Slave data is sampled mid-high, at the q1/q2 boundary.
        if (m_state_q == M_RDATA && tick && qtr_q == 2'd1)
          rx_sh_d = {rx_sh_q[6:0], sda_bus};
        if (bit_end) begin
          case (m_state_q)
            M_START: m_state_d = M_ADDR;
            M_ADDR: begin
              if (bcnt_q == 3'd7) begin
                m_state_d = M_ADDR_ACK;
                bcnt_d    = 3'd0;
              end else begin
                bcnt_d  = bcnt_q + 3'd1;
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
              end
            end
            M_ADDR_ACK: begin
              bcnt_d = 3'd0;
              if (wr_q) begin
                m_state_d = M_WDATA;
                tx_sh_d   = wdata_q;
              end else begin
                m_state_d = M_RDATA;
              end
            end
            M_WDATA: begin
              if (bcnt_q == 3'd7) begin
                m_state_d = M_WACK;
                bcnt_d    = 3'd0;
              end else begin
                bcnt_d  = bcnt_q + 3'd1;
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
              end
            end
            M_WACK:  m_state_d = M_STOP;
            M_RDATA: begin
              if (bcnt_q == 3'd7) begin
                m_state_d = M_MNACK;
                bcnt_d    = 3'd0;
              end else begin
                bcnt_d = bcnt_q + 3'd1;
              end
            end
            M_MNACK: m_state_d = M_STOP;
            M_STOP:  m_state_d = M_DONE;
            default: ;
          endcase
        end
      end
    endcase

    // Bus levels follow the current state/quarter, registered one clk later.
    case (m_state_q)
      M_START: begin
        scl_d   = (qtr_q != 2'd3);
        m_drv_d = (qtr_q != 2'd0);
      end
      M_STOP: begin
        scl_d   = (qtr_q != 2'd0);
        m_drv_d = (qtr_q < 2'd2);
      end
      M_ADDR, M_WDATA: begin
        scl_d   = scl_hi_qtr;
        m_drv_d = ~tx_sh_q[7];
      end
      M_ADDR_ACK, M_WACK, M_RDATA, M_MNACK: scl_d = scl_hi_qtr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state_q   <= M_IDLE;
      cdiv_q      <= '0;
      qtr_q       <= 2'd0;
      bcnt_q      <= 3'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      rx_sh_q     <= 8'h00;
      rdata_q     <= 8'h00;
      done_q      <= 1'b0;
      scl_q       <= 1'b1;
      m_drv_q     <= 1'b0;
      newd_prev_q <= 1'b0;
    end else begin
      m_state_q   <= m_state_d;
      cdiv_q      <= cdiv_d;
      qtr_q       <= qtr_d;
      bcnt_q      <= bcnt_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      scl_q       <= scl_d;
      m_drv_q     <= m_drv_d;
      newd_prev_q <= newd;
    end
  end

  // Slave: samples on SCL rise, changes SDA right after SCL fall.
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shifted, rd_byte;
  assign scl_rise  = scl_q & ~s_scl_prev_q;
  assign scl_fall  = ~scl_q & s_scl_prev_q;
  assign start_det = scl_q & s_scl_prev_q & s_sda_prev_q & ~sda_bus;
  assign stop_det  = scl_q & s_scl_prev_q & ~s_sda_prev_q & sda_bus;
  assign shifted   = {s_sh_q[6:0], sda_bus};
  assign rd_byte   = mem_q[s_addr_q];

  always_comb begin
    s_state_d = s_state_q;
    s_cnt_d   = s_cnt_q;
    s_sh_d    = s_sh_q;
    s_addr_d  = s_addr_q;
    s_rw_d    = s_rw_q;
    s_drv_d   = s_drv_q;
    mem_we    = 1'b0;
    mem_wdata = shifted;

    if (stop_det) begin
      s_state_d = S_IDLE;
      s_drv_d   = 1'b0;
    end else if (start_det) begin
      s_state_d = S_ADDR;
      s_cnt_d   = 4'd0;
      s_drv_d   = 1'b0;
    end else begin
      case (s_state_q)
        S_ADDR: begin
          if (scl_rise) begin
            s_sh_d  = shifted;
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == 4'd7) begin
              s_addr_d = shifted[7:1];
              s_rw_d   = shifted[0];
            end
          end else if (scl_fall && s_cnt_q == 4'd8) begin
            s_drv_d   = 1'b1;
            s_state_d = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            s_cnt_d = 4'd0;
            if (s_rw_q) begin
              s_sh_d    = rd_byte;
              s_drv_d   = ~rd_byte[7];
              s_state_d = S_RDATA;
            end else begin
              s_drv_d   = 1'b0;
              s_state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            s_sh_d  = shifted;
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == 4'd7) mem_we = 1'b1;
          end else if (scl_fall && s_cnt_q == 4'd8) begin
            s_drv_d   = 1'b1;
            s_state_d = S_WACK;
          end
        end
        S_WACK: begin
          if (scl_fall) begin
            s_drv_d   = 1'b0;
            s_state_d = S_WAIT;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (s_cnt_q == 4'd7) begin
              s_drv_d   = 1'b0;
              s_state_d = S_WAIT;
            end else begin
              s_sh_d  = {s_sh_q[6:0], 1'b0};
              s_drv_d = ~s_sh_q[6];
              s_cnt_d = s_cnt_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_state_q    <= S_IDLE;
      s_cnt_q      <= 4'd0;
      s_sh_q       <= 8'h00;
      s_addr_q     <= 7'h00;
      s_rw_q       <= 1'b0;
      s_drv_q      <= 1'b0;
      s_scl_prev_q <= 1'b1;
      s_sda_prev_q <= 1'b1;
      for (int i = 0; i < 128; i++) mem_q[i] <= 8'h00;
    end else begin
      s_state_q    <= s_state_d;
      s_cnt_q      <= s_cnt_d;
      s_sh_q       <= s_sh_d;
      s_addr_q     <= s_addr_d;
      s_rw_q       <= s_rw_d;
      s_drv_q      <= s_drv_d;
      s_scl_prev_q <= scl_q;
      s_sda_prev_q <= sda_bus;
      if (mem_we) mem_q[s_addr_q] <= mem_wdata;
    end
  end

  assign rdata = rdata_q;
  assign done  = done_q;
`ifdef I2C_BUS_OBS_EN
  assign scl_o = scl_q;
  assign sda_o = sda_bus;
`endif

endmodule

// File: tb/tb_i2c_loop_design.sv
// Directed bench for i2c_loop_design: reference memory model feeds a scoreboard of
// expected read data and done latency, checked when done pulses.
module tb_i2c_loop_design;

  localparam int LAT = 321;

  logic       clk = 1'b0;
  logic       rst;
  logic       newd;
  logic       wr;
  logic [7:0] wdata;
  logic [6:0] addr;
  logic [7:0] rdata;
  logic       done;
`ifdef I2C_BUS_OBS_EN
  logic       scl_o, sda_o;
`endif

  i2c_loop_design #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .newd  (newd),
    .wr    (wr),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .done  (done)
`ifdef I2C_BUS_OBS_EN
    ,
    .scl_o (scl_o),
    .sda_o (sda_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [128];
  logic [7:0] last_rd;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done must match a queued transaction.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc - e.start, LAT);
        if (e.rd) chk("rdata", rdata, e.data);
      end
    end
  end

  task automatic run(input bit w, input logic [6:0] a, input logic [7:0] d,
                     input bit hold, input bit scram);
    exp_t e;
    bit   seen;
    @(negedge clk);
    wr = w; addr = a; wdata = d; newd = 1'b1;
    e.rd = !w;
    e.data = w ? 8'h00 : model[a];
    e.start = cyc + 1;
    sb.push_back(e);
    if (w) model[a] = d;
    else last_rd = model[a];
    seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (scram && n == 40) begin
        addr = ~a; wdata = ~d; wr = ~w;
      end
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_one_clk", done, 0);
    chk("rdata_after", rdata, last_rd);
    if (!hold) newd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    last_rd = 8'h00;
    rst = 1'b0; newd = 1'b0; wr = 1'b0; wdata = 8'h00; addr = 7'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_done", done, 0);
`ifdef I2C_BUS_OBS_EN
    chk("reset_scl", scl_o, 1);
    chk("reset_sda", sda_o, 1);
`endif
    rst = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    // Loopback
    run(1'b1, 7'h10, 8'h27, 1'b0, 1'b0);
    run(1'b0, 7'h10, 8'h00, 1'b0, 1'b0);

    // Distinct addresses and boundaries
    run(1'b1, 7'h10, 8'hA5, 1'b0, 1'b0);
    run(1'b1, 7'h7F, 8'h3C, 1'b0, 1'b0);
    run(1'b1, 7'h00, 8'hFF, 1'b0, 1'b0);
    run(1'b0, 7'h10, 8'h00, 1'b0, 1'b0);
    run(1'b0, 7'h7F, 8'h00, 1'b0, 1'b0);
    run(1'b0, 7'h00, 8'h00, 1'b0, 1'b0);
    run(1'b0, 7'h11, 8'h00, 1'b0, 1'b0);

    // Held newd with inputs scrambled mid-frame
    run(1'b1, 7'h22, 8'h5A, 1'b1, 1'b1);
    cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("held_no_restart", cnt, 0);
    newd = 1'b0;
    repeat (3) @(negedge clk);
    run(1'b0, 7'h22, 8'h00, 1'b0, 1'b0);
    run(1'b0, 7'h5D, 8'h00, 1'b0, 1'b0);

    // Reset during the data byte of a write
    @(negedge clk);
    wr = 1'b1; addr = 7'h33; wdata = 8'h99; newd = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    last_rd = 8'h00;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 8'h00);
`ifdef I2C_BUS_OBS_EN
    chk("abort_sda_released", sda_o, 1);
`endif
    newd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run(1'b0, 7'h33, 8'h00, 1'b0, 1'b0);
    run(1'b0, 7'h10, 8'h00, 1'b0, 1'b0);

`ifdef I2C_BUS_OBS_EN
    begin : obs_blk
      exp_t       e;
      logic       ps, pd, s, d;
      bit         fell;
      logic       fall_scl, rise_scl;
      logic [7:0] ab;
      int         nr;
      ps = 1'b1; pd = 1'b1; fell = 0; nr = 0; ab = 8'h00;
      fall_scl = 1'b0; rise_scl = 1'b0;
      @(negedge clk);
      wr = 1'b1; addr = 7'h10; wdata = 8'h5B; newd = 1'b1;
      e.rd = 1'b0; e.data = 8'h00; e.start = cyc + 1;
      sb.push_back(e);
      model[7'h10] = 8'h5B;
      repeat (340) begin
        @(negedge clk);
        s = scl_o; d = sda_o;
        if (!fell && pd && !d) begin
          fell = 1; fall_scl = s;
        end else if (fell && nr < 8 && !ps && s) begin
          ab = {ab[6:0], d}; nr++;
        end
        if (!pd && d) rise_scl = s;
        ps = s; pd = d;
      end
      newd = 1'b0;
      chk("obs_start_scl_high", fall_scl, 1);
      chk("obs_addr_byte", ab, 8'h20);
      chk("obs_stop_scl_high", rise_scl, 1);
      chk("obs_idle_scl", scl_o, 1);
      chk("obs_idle_sda", sda_o, 1);
      repeat (3) @(negedge clk);
    end
    run(1'b0, 7'h10, 8'h00, 1'b0, 1'b0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
